// File: rtl/if_mem_stage_if.sv
`default_nettype none
// ============================================================================
// if_mem_stage_if : SRAM-like instruction port (req/addr_ok/data_ok)
// Revision: 1.0
// ============================================================================
interface if_mem_stage_if #(
    parameter int INST_W = 32
);
    logic              inst_req;
    logic [31:0]       inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [INST_W-1:0] inst_rdata;

    // Fetch stage side
    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    // Instruction memory side
    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_mem_stage.sv
`default_nettype none
// ============================================================================
// if_mem_stage : one-outstanding instruction fetch with flush/cancel handling
// Optional macro IF_ADEF_CHECK_EN enables the misaligned-PC address error path.
// Revision: 1.0
// ============================================================================
module if_mem_stage #(
    parameter int INST_W = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [31:0]       pc,
    input  wire logic              pc_valid,
    output logic                   if_allowin,
    input  wire logic              flush,
    if_mem_stage_if.master         inst_bus,
    output logic                   id_valid,
    input  wire logic              id_allowin,
    output logic [31:0]            id_pc,
    output logic [INST_W-1:0]      id_inst,
    output logic                   id_adef
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_cancel;
    logic [31:0]       r_pc;
    logic              r_allowin;
    logic              r_inst_req;
    logic              r_hold;
    logic [31:0]       r_id_pc;
    logic [INST_W-1:0] r_id_inst;
    logic              w_accept;
    logic              w_misaligned;

    assign w_accept = pc_valid && !flush;

`ifdef IF_ADEF_CHECK_EN
    logic r_id_adef;
    assign w_misaligned = (pc[1:0] != 2'b00);
    assign id_adef      = r_id_adef;
`else
    assign w_misaligned = 1'b0;
    assign id_adef      = 1'b0;
`endif

    // All control outputs are registered alongside the state; only id_valid
    // looks at flush combinationally so a redirect suppresses it immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cancel   <= 1'b0;
            r_pc       <= 32'd0;
            r_allowin  <= 1'b1;
            r_inst_req <= 1'b0;
            r_hold     <= 1'b0;
            r_id_pc    <= 32'd0;
            r_id_inst  <= '0;
`ifdef IF_ADEF_CHECK_EN
            r_id_adef  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pc      <= pc;
                        r_allowin <= 1'b0;
                        if (w_misaligned) begin
                            r_state   <= S_HOLD;
                            r_hold    <= 1'b1;
                            r_id_pc   <= pc;
                            r_id_inst <= '0;
`ifdef IF_ADEF_CHECK_EN
                            r_id_adef <= 1'b1;
`endif
                        end else begin
                            r_state    <= S_REQ;
                            r_inst_req <= 1'b1;
                        end
                    end
                end

                S_REQ: begin
                    // The request is never withdrawn; a flush only marks it stale.
                    if (flush) begin
                        r_cancel <= 1'b1;
                    end
                    if (inst_bus.inst_addr_ok) begin
                        r_state    <= S_WAIT;
                        r_inst_req <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (inst_bus.inst_data_ok) begin
                        if (r_cancel || flush) begin
                            r_state   <= S_IDLE;
                            r_cancel  <= 1'b0;
                            r_allowin <= 1'b1;
                        end else begin
                            r_state   <= S_HOLD;
                            r_hold    <= 1'b1;
                            r_id_pc   <= r_pc;
                            r_id_inst <= inst_bus.inst_rdata;
                        end
                    end else if (flush) begin
                        r_cancel <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (id_allowin || flush) begin
                        r_state   <= S_IDLE;
                        r_hold    <= 1'b0;
                        r_allowin <= 1'b1;
`ifdef IF_ADEF_CHECK_EN
                        r_id_adef <= 1'b0;
`endif
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_cancel   <= 1'b0;
                    r_allowin  <= 1'b1;
                    r_inst_req <= 1'b0;
                    r_hold     <= 1'b0;
                end
            endcase
        end
    end

    assign if_allowin         = r_allowin;
    assign inst_bus.inst_req  = r_inst_req;
    assign inst_bus.inst_addr = r_pc;
    assign id_valid           = r_hold && !flush;
    assign id_pc              = r_id_pc;
    assign id_inst            = r_id_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_if_mem_stage : scenario tasks with a scoreboard of expected decode outputs
// Revision: 1.0
// ============================================================================
module tb_if_mem_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        if_allowin;
    logic        flush;
    logic        id_valid;
    logic        id_allowin;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adef;

    int total;
    int bad;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    if_mem_stage_if #(.INST_W(32)) bus ();

    if_mem_stage #(.INST_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .if_allowin (if_allowin),
        .flush      (flush),
        .inst_bus   (bus),
        .id_valid   (id_valid),
        .id_allowin (id_allowin),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_adef    (id_adef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fetch(input logic [31:0] a);
        pc       = a;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; pc = '0; pc_valid = 0; flush = 0; id_allowin = 0;
        bus.inst_addr_ok = 0; bus.inst_data_ok = 0; bus.inst_rdata = '0;
        tick(); tick();
        total++; if (if_allowin !== 1'b1) begin bad++; $display("FAIL rst_allowin: got %b want 1", if_allowin); end
        total++; if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.inst_req); end
        total++; if (bus.inst_addr !== 32'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.inst_addr); end
        total++; if ({id_valid, id_adef} !== 2'b00) begin bad++; $display("FAIL rst_valid_adef: got %b want 00", {id_valid, id_adef}); end
        total++; if ({id_pc, id_inst} !== 64'd0) begin bad++; $display("FAIL rst_id: got %h want 0", {id_pc, id_inst}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        total++; if (if_allowin !== 1'b1) begin bad++; $display("FAIL norm_allowin0: got %b want 1", if_allowin); end
        start_fetch(32'hBFC00000);
        sb.push_back('{32'hBFC00000, 32'h24010001, 1'b0});
        total++; if (bus.inst_req !== 1'b1) begin bad++; $display("FAIL norm_req: got %b want 1", bus.inst_req); end
        total++; if (bus.inst_addr !== 32'hBFC00000) begin bad++; $display("FAIL norm_addr: got %h want bfc00000", bus.inst_addr); end
        total++; if (if_allowin !== 1'b0) begin bad++; $display("FAIL norm_busy: got %b want 0", if_allowin); end
        bus.inst_addr_ok = 1; tick(); bus.inst_addr_ok = 0;
        total++; if ({bus.inst_req, id_valid} !== 2'b00) begin bad++; $display("FAIL norm_wait: got %b want 00", {bus.inst_req, id_valid}); end
        bus.inst_data_ok = 1; bus.inst_rdata = 32'h24010001; tick(); bus.inst_data_ok = 0;
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL norm_valid: got %b want 1", id_valid); end
        if (sb.size() == 0) begin total++; bad++; $display("FAIL norm_sb: got empty want entry"); end
        else begin
            e = sb.pop_front();
            total++; if ({id_pc, id_inst, id_adef} !== {e.pc, e.inst, e.adef})
                begin bad++; $display("FAIL norm_data: got %h %h %b want %h %h %b", id_pc, id_inst, id_adef, e.pc, e.inst, e.adef); end
        end
        id_allowin = 1; tick(); id_allowin = 0;
        total++; if ({if_allowin, id_valid} !== 2'b10) begin bad++; $display("FAIL norm_release: got %b want 10", {if_allowin, id_valid}); end
    endtask

    task automatic test_backpressure();
        start_fetch(32'hBFC00004);
        sb.push_back('{32'hBFC00004, 32'h8C020010, 1'b0});
        bus.inst_addr_ok = 1; tick(); bus.inst_addr_ok = 0;
        bus.inst_data_ok = 1; bus.inst_rdata = 32'h8C020010; tick(); bus.inst_data_ok = 0;
        bus.inst_rdata = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            total++; if ({id_valid, if_allowin, bus.inst_req} !== 3'b100)
                begin bad++; $display("FAIL bp_ctrl[%0d]: got %b want 100", i, {id_valid, if_allowin, bus.inst_req}); end
            total++; if ({id_pc, id_inst} !== {sb[0].pc, sb[0].inst})
                begin bad++; $display("FAIL bp_stable[%0d]: got %h %h want %h %h", i, id_pc, id_inst, sb[0].pc, sb[0].inst); end
            tick();
        end
        e = sb.pop_front();
        total++; if ({id_valid, id_pc, id_inst} !== {1'b1, e.pc, e.inst})
            begin bad++; $display("FAIL bp_data: got %b %h %h want 1 %h %h", id_valid, id_pc, id_inst, e.pc, e.inst); end
        id_allowin = 1; tick(); id_allowin = 0;
        total++; if (if_allowin !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", if_allowin); end
    endtask

    task automatic test_flush_wait();
        start_fetch(32'hBFC00008);
        bus.inst_addr_ok = 1; tick(); bus.inst_addr_ok = 0;
        flush = 1; tick(); flush = 0;
        total++; if (if_allowin !== 1'b0) begin bad++; $display("FAIL fw_still_wait: got %b want 0", if_allowin); end
        tick();
        bus.inst_data_ok = 1; bus.inst_rdata = 32'hDEADBEEF; tick(); bus.inst_data_ok = 0;
        total++; if ({id_valid, if_allowin} !== 2'b01) begin bad++; $display("FAIL fw_drop: got %b want 01", {id_valid, if_allowin}); end
        start_fetch(32'hBFC00100);
        sb.push_back('{32'hBFC00100, 32'h3C1D8000, 1'b0});
        total++; if (bus.inst_addr !== 32'hBFC00100) begin bad++; $display("FAIL fw_next_addr: got %h want bfc00100", bus.inst_addr); end
        bus.inst_addr_ok = 1; tick(); bus.inst_addr_ok = 0;
        bus.inst_data_ok = 1; bus.inst_rdata = 32'h3C1D8000; tick(); bus.inst_data_ok = 0;
        if (id_valid !== 1'b1 || sb.size() == 0) begin total++; bad++; $display("FAIL fw_next_valid: got %b want 1", id_valid); end
        else begin
            e = sb.pop_front();
            total++; if ({id_pc, id_inst} !== {e.pc, e.inst})
                begin bad++; $display("FAIL fw_next_data: got %h %h want %h %h", id_pc, id_inst, e.pc, e.inst); end
        end
        id_allowin = 1; tick(); id_allowin = 0;
    endtask

    task automatic test_flush_req();
        start_fetch(32'hBFC00010);
        flush = 1; tick(); flush = 0;
        for (int i = 0; i < 2; i++) begin
            total++; if ({bus.inst_req, id_valid} !== 2'b10) begin bad++; $display("FAIL fr_held[%0d]: got %b want 10", i, {bus.inst_req, id_valid}); end
            tick();
        end
        bus.inst_addr_ok = 1; tick(); bus.inst_addr_ok = 0;
        total++; if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL fr_req_drop: got %b want 0", bus.inst_req); end
        bus.inst_data_ok = 1; bus.inst_rdata = 32'h11111111; tick(); bus.inst_data_ok = 0;
        total++; if ({id_valid, if_allowin} !== 2'b01) begin bad++; $display("FAIL fr_discard: got %b want 01", {id_valid, if_allowin}); end
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fr_no_valid: got %b want 0", id_valid); end
    endtask

    task automatic test_flush_edge();
        start_fetch(32'hBFC00018);
        bus.inst_addr_ok = 1; tick(); bus.inst_addr_ok = 0;
        flush = 1; bus.inst_data_ok = 1; bus.inst_rdata = 32'h22222222; tick();
        flush = 0; bus.inst_data_ok = 0;
        total++; if ({id_valid, if_allowin} !== 2'b01) begin bad++; $display("FAIL fd_drop: got %b want 01", {id_valid, if_allowin}); end
        start_fetch(32'hBFC00020);
        sb.push_back('{32'hBFC00020, 32'h33333333, 1'b0});
        bus.inst_addr_ok = 1; tick(); bus.inst_addr_ok = 0;
        bus.inst_data_ok = 1; bus.inst_rdata = 32'h33333333; tick(); bus.inst_data_ok = 0;
        if (id_valid !== 1'b1 || sb.size() == 0) begin total++; bad++; $display("FAIL fh_valid: got %b want 1", id_valid); end
        else begin
            e = sb.pop_front();
            total++; if ({id_pc, id_inst} !== {e.pc, e.inst})
                begin bad++; $display("FAIL fh_data: got %h %h want %h %h", id_pc, id_inst, e.pc, e.inst); end
        end
        flush = 1; #1;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL fh_suppress: got %b want 0", id_valid); end
        tick(); flush = 0;
        total++; if ({id_valid, if_allowin} !== 2'b01) begin bad++; $display("FAIL fh_idle: got %b want 01", {id_valid, if_allowin}); end
    endtask

    task automatic test_misaligned();
`ifdef IF_ADEF_CHECK_EN
        start_fetch(32'hBFC00002);
        sb.push_back('{32'hBFC00002, 32'h00000000, 1'b1});
        total++; if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL ma_no_req: got %b want 0", bus.inst_req); end
        if (id_valid !== 1'b1) begin total++; bad++; $display("FAIL ma_valid: got %b want 1", id_valid); end
        else begin
            e = sb.pop_front();
            total++; if ({id_pc, id_inst, id_adef} !== {e.pc, e.inst, e.adef})
                begin bad++; $display("FAIL ma_data: got %h %h %b want %h %h %b", id_pc, id_inst, id_adef, e.pc, e.inst, e.adef); end
        end
        id_allowin = 1; tick(); id_allowin = 0;
        total++; if ({if_allowin, id_adef} !== 2'b10) begin bad++; $display("FAIL ma_clear: got %b want 10", {if_allowin, id_adef}); end
`else
        start_fetch(32'hBFC00002);
        sb.push_back('{32'hBFC00002, 32'h44444444, 1'b0});
        total++; if ({bus.inst_req, bus.inst_addr} !== {1'b1, 32'hBFC00002})
            begin bad++; $display("FAIL ma_req: got %b %h want 1 bfc00002", bus.inst_req, bus.inst_addr); end
        bus.inst_addr_ok = 1; tick(); bus.inst_addr_ok = 0;
        bus.inst_data_ok = 1; bus.inst_rdata = 32'h44444444; tick(); bus.inst_data_ok = 0;
        if (id_valid !== 1'b1) begin total++; bad++; $display("FAIL ma_valid: got %b want 1", id_valid); end
        else begin
            e = sb.pop_front();
            total++; if ({id_pc, id_inst, id_adef} !== {e.pc, e.inst, e.adef})
                begin bad++; $display("FAIL ma_data: got %h %h %b want %h %h %b", id_pc, id_inst, id_adef, e.pc, e.inst, e.adef); end
        end
        id_allowin = 1; tick(); id_allowin = 0;
`endif
    endtask

    task automatic test_ignored();
        pc = 32'hBFC00040; pc_valid = 1; flush = 1; tick(); pc_valid = 0; flush = 0;
        total++; if ({if_allowin, bus.inst_req} !== 2'b10) begin bad++; $display("FAIL ig_pc_flush: got %b want 10", {if_allowin, bus.inst_req}); end
        bus.inst_data_ok = 1; bus.inst_rdata = 32'h55555555; tick(); bus.inst_data_ok = 0;
        total++; if ({id_valid, if_allowin} !== 2'b01) begin bad++; $display("FAIL ig_stray_data: got %b want 01", {id_valid, if_allowin}); end
    endtask

    task automatic test_async_reset();
        start_fetch(32'hBFC00050);
        #2 reset = 1'b0; #1;
        total++; if ({bus.inst_req, if_allowin, bus.inst_addr} !== {1'b0, 1'b1, 32'd0})
            begin bad++; $display("FAIL ar_clear: got %b %b %h want 0 1 0", bus.inst_req, if_allowin, bus.inst_addr); end
        tick(); reset = 1'b1; tick();
        start_fetch(32'hBFC00060);
        sb.push_back('{32'hBFC00060, 32'h66666666, 1'b0});
        bus.inst_addr_ok = 1; tick(); bus.inst_addr_ok = 0;
        bus.inst_data_ok = 1; bus.inst_rdata = 32'h66666666; tick(); bus.inst_data_ok = 0;
        if (id_valid !== 1'b1) begin total++; bad++; $display("FAIL ar_restart: got %b want 1", id_valid); end
        else begin
            e = sb.pop_front();
            total++; if ({id_pc, id_inst} !== {e.pc, e.inst})
                begin bad++; $display("FAIL ar_data: got %h %h want %h %h", id_pc, id_inst, e.pc, e.inst); end
        end
        id_allowin = 1; tick(); id_allowin = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_normal();
        test_backpressure();
        test_flush_wait();
        test_flush_req();
        test_flush_edge();
        test_misaligned();
        test_ignored();
        test_async_reset();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_mem_stage.md
# if_mem_stage

Instruction-fetch memory stage that sits directly downstream of the PC register stage. It accepts one valid PC at a time and issues it on an SRAM-like instruction port (req/addr_ok/data_ok). It holds the returned instruction until the decode stage accepts it. A redirect (`flush`) cancels in-flight work, and responses for cancelled requests are discarded.

## Interface
- `INST_W`, 32, instruction and read-data width
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pc`  in  32  PC from the PC register stage
- `pc_valid`  in  1  `pc` is valid (PC stage go-on valid)
- `if_allowin`  out  1  this stage accepts `pc` this cycle (drives PC stage post-allowin)
- `flush`  in  1  redirect: kill the current fetch
- `inst_req`  out  1  instruction memory request
- `inst_addr`  out  32  request address
- `inst_addr_ok`  in  1  request accepted this cycle
- `inst_data_ok`  in  1  read data returned this cycle
- `inst_rdata`  in  INST_W  read data
- `id_valid`  out  1  `id_pc`/`id_inst` valid toward decode
- `id_allowin`  in  1  decode accepts this cycle
- `id_pc`  out  32  PC of the held instruction
- `id_inst`  out  INST_W  held instruction
- `id_adef`  out  1  fetch address error flag; constant 0 unless the feature is enabled

## Operation
- States: IDLE, REQ, WAIT, HOLD, plus a `cancel` flag.
- Outputs:
  - `if_allowin` = (state==IDLE).
  - `inst_req` = (state==REQ).
  - `inst_addr` = latched `pc_r`.
  - `id_valid` = (state==HOLD) && !`flush`.
- IDLE:
  - On `pc_valid` && !`flush`, latch `pc_r`=`pc` and go to REQ.
  - `pc_valid` in the same cycle as `flush` is ignored.
- REQ:
  - `inst_req` stays high until `inst_addr_ok`; a request is never withdrawn.
  - On `inst_addr_ok`, go to WAIT.
  - `flush` in REQ sets `cancel`=1 and the request continues.
- WAIT:
  - On `inst_data_ok` with `cancel`=0 and no `flush`, capture `id_inst`=`inst_rdata`, set `id_pc`=`pc_r`, go to HOLD.
  - On `inst_data_ok` with `cancel`=1 or `flush`, discard the data, clear `cancel`, go to IDLE.
  - `flush` without `data_ok` sets `cancel`=1.
- HOLD:
  - On `id_allowin`, go to IDLE.
  - On `flush`, go to IDLE; `id_valid` is suppressed in that same cycle.
- `inst_data_ok` outside WAIT is a protocol error and is ignored.
- At most one request is outstanding.

## Timing
- Reset values (async, `reset`=0):
  - state=IDLE, `cancel`=0.
  - `inst_req`=0, `inst_addr`=0, `pc_r`=0.
  - `id_valid`=0, `id_pc`=0, `id_inst`=0, `id_adef`=0.
  - `if_allowin`=1 after reset.
- Best-case latency: PC accepted at edge N; `inst_req` high in cycle N+1.
  - If `addr_ok` arrives in N+1 and `data_ok` in N+2, `id_valid` is high in N+3.
- Minimum spacing between accepted PCs: 4 cycles (IDLE→REQ→WAIT→HOLD→IDLE).
- Reset deassertion mid-transaction: the block restarts in IDLE. The memory side must be reset together with this block.

## Configuration
- Macro: `IF_ADEF_CHECK_EN`.
- Defined: a PC accepted in IDLE with `pc[1:0]`≠0 goes directly to HOLD.
  - No memory request is issued.
  - `id_pc`=`pc`, `id_inst`=0 (a nop encoding), `id_adef`=1.
  - Leaving HOLD clears `id_adef`.
  - `flush` behaves as for a normal HOLD.
- Undefined: no alignment check is made; misaligned PCs are fetched normally and `id_adef` is tied to 0.

## Test plan
- Normal fetch: `pc`=0xBFC00000 valid, `addr_ok` same cycle as req, `data_ok` the next cycle with 0x24010001 → `id_valid` 3 cycles after accept with `id_pc`=0xBFC00000, `id_inst`=0x24010001; `if_allowin` returns to 1 the cycle after `id_allowin`.
- Decode backpressure: `id_allowin`=0 for 5 cycles in HOLD → `id_valid`, `id_pc` and `id_inst` stable, `if_allowin`=0 and `inst_req`=0 throughout.
- Flush in WAIT: `flush` pulse before `data_ok`; `data_ok` then returns 0xDEADBEEF → no `id_valid`, state back to IDLE, next PC 0xBFC00100 fetched correctly.
- Flush in REQ with `addr_ok` delayed 3 cycles → `inst_req` held until `addr_ok`, the response is discarded, `id_valid` never asserted for it.
- Flush and `data_ok` in the same cycle, and flush in HOLD → data dropped or `id_valid` deasserted the same cycle, IDLE the next cycle.
- With `IF_ADEF_CHECK_EN`: `pc`=0xBFC00002 → no `inst_req`, `id_valid`=1 the next cycle with `id_adef`=1 and `id_inst`=0.
- Without the macro: `pc`=0xBFC00002 → normal fetch with `inst_addr`=0xBFC00002 and `id_adef`=0.
